// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared state, opcode, ALUOp and datapath select encodings
package cpu_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTE  = 4'd6,
    ALUWB    = 4'd7,
    BRANCH   = 4'd8,
    ILLEGAL  = 4'd9
  } state_t;

  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT  = 2'b00;
  localparam logic [1:0] RES_MEMDATA = 2'b01;
  localparam logic [1:0] RES_ALU     = 2'b10;

endpackage

// File: rtl/instr_counter.sv
// rtl/instr_counter.sv - retired-instruction counter, wraps modulo 2^CNT_W
module instr_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             retire,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (retire) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multicycle core control FSM; PERF_CNT_EN adds the instret counter
module multicycle_control
  import cpu_pkg::*;
#(
  parameter int OPCODE_W = 7,
  parameter int ALUOP_W  = 2
`ifdef PERF_CNT_EN
  ,
  parameter int CNT_W    = 32
`endif
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                Zero,
  input  logic                mem_ready,
  output logic                mem_req,
  output logic                mem_we,
  output logic                AdrSrc,
  output logic                IRWrite,
  output logic                PCWrite,
  output logic                RegWrite,
  output logic [1:0]          ALUSrcA,
  output logic [1:0]          ALUSrcB,
  output logic [ALUOP_W-1:0]  ALUOp,
  output logic [1:0]          ResultSrc,
  output logic                illegal,
  output logic [3:0]          state_o
`ifdef PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]    instret
`endif
);

  state_t     state;
  state_t     state_nxt;
  logic [1:0] aluop_sel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FETCH;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FETCH:    if (mem_ready) state_nxt = DECODE;
      DECODE: begin
        if (opcode == OPCODE_W'(OP_LW) || opcode == OPCODE_W'(OP_SW)) state_nxt = MEMADR;
        else if (opcode == OPCODE_W'(OP_RTYPE))                        state_nxt = EXECUTE;
        else if (opcode == OPCODE_W'(OP_BEQ))                          state_nxt = BRANCH;
        else                                                           state_nxt = ILLEGAL;
      end
      MEMADR:   state_nxt = (opcode == OPCODE_W'(OP_LW)) ? MEMREAD : MEMWRITE;
      MEMREAD:  if (mem_ready) state_nxt = MEMWB;
      MEMWB:    state_nxt = FETCH;
      MEMWRITE: if (mem_ready) state_nxt = FETCH;
      EXECUTE:  state_nxt = ALUWB;
      ALUWB:    state_nxt = FETCH;
      BRANCH:   state_nxt = FETCH;
      ILLEGAL:  state_nxt = ILLEGAL;
      default:  state_nxt = FETCH;
    endcase
  end

  // Only IRWrite and the two PCWrite cases look at inputs; everything else is pure state decode.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    AdrSrc    = 1'b0;
    IRWrite   = 1'b0;
    PCWrite   = 1'b0;
    RegWrite  = 1'b0;
    ALUSrcA   = SRCA_PC;
    ALUSrcB   = SRCB_RS2;
    aluop_sel = ALUOP_ADD;
    ResultSrc = RES_ALUOUT;
    illegal   = 1'b0;
    case (state)
      FETCH: begin
        mem_req   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALU;
        IRWrite   = mem_ready;
        PCWrite   = mem_ready;
      end
      DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
      end
      MEMADR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
      end
      MEMREAD: begin
        mem_req = 1'b1;
        AdrSrc  = 1'b1;
      end
      MEMWB: begin
        ResultSrc = RES_MEMDATA;
        RegWrite  = 1'b1;
      end
      MEMWRITE: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        AdrSrc  = 1'b1;
      end
      EXECUTE: begin
        ALUSrcA   = SRCA_RS1;
        ALUSrcB   = SRCB_RS2;
        aluop_sel = ALUOP_FUNCT;
      end
      ALUWB: begin
        ResultSrc = RES_ALUOUT;
        RegWrite  = 1'b1;
      end
      BRANCH: begin
        ALUSrcA   = SRCA_RS1;
        ALUSrcB   = SRCB_RS2;
        aluop_sel = ALUOP_SUB;
        ResultSrc = RES_ALUOUT;
        PCWrite   = Zero;
      end
      ILLEGAL:  illegal = 1'b1;
      default: ;
    endcase
  end

  assign ALUOp   = ALUOP_W'(aluop_sel);
  assign state_o = state;

`ifdef PERF_CNT_EN
  logic retire;

  assign retire = (state == MEMWB) || (state == ALUWB) || (state == BRANCH) ||
                  ((state == MEMWRITE) && mem_ready);

  instr_counter #(
    .CNT_W (CNT_W)
  ) u_instr_counter (
    .clk    (clk),
    .rst_n  (rst_n),
    .retire (retire),
    .count  (instret)
  );
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - vector-table bench for multicycle_control; PERF_CNT_EN enables instret checks
module tb_multicycle_control;

  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] BQ  = 7'b1100011;
  localparam logic [6:0] BAD = 7'b1111111;

  // {mem_req, mem_we, AdrSrc, IRWrite, PCWrite, RegWrite, ALUSrcA, ALUSrcB, ALUOp, ResultSrc, illegal}
  localparam logic [14:0] O_FW  = 15'b100000_00_10_00_10_0;
  localparam logic [14:0] O_FR  = 15'b100110_00_10_00_10_0;
  localparam logic [14:0] O_DEC = 15'b000000_01_01_00_00_0;
  localparam logic [14:0] O_MA  = 15'b000000_10_01_00_00_0;
  localparam logic [14:0] O_MR  = 15'b101000_00_00_00_00_0;
  localparam logic [14:0] O_MWB = 15'b000001_00_00_00_01_0;
  localparam logic [14:0] O_MW  = 15'b111000_00_00_00_00_0;
  localparam logic [14:0] O_EX  = 15'b000000_10_00_10_00_0;
  localparam logic [14:0] O_AWB = 15'b000001_00_00_00_00_0;
  localparam logic [14:0] O_BR1 = 15'b000010_10_00_01_00_0;
  localparam logic [14:0] O_BR0 = 15'b000000_10_00_01_00_0;
  localparam logic [14:0] O_ILL = 15'b000000_00_00_00_00_1;

  typedef struct {
    logic [6:0]  op;
    logic        zero;
    logic        rdy;
    logic [3:0]  st;
    logic [14:0] out;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  opcode;
  logic        zero;
  logic        mem_ready;
  logic        mem_req, mem_we, AdrSrc, IRWrite, PCWrite, RegWrite, illegal;
  logic [1:0]  ALUSrcA, ALUSrcB, ALUOp, ResultSrc;
  logic [3:0]  state_o;
`ifdef PERF_CNT_EN
  logic [3:0]  instret;
  logic [3:0]  saved_instret;
`endif

  int   checks   = 0;
  int   failures = 0;
  int   retired  = 0;
  vec_t tbl[$];

  always #5 clk = ~clk;

  multicycle_control #(
    .OPCODE_W (7),
    .ALUOP_W  (2)
`ifdef PERF_CNT_EN
    ,
    .CNT_W    (4)
`endif
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .opcode    (opcode),
    .Zero      (zero),
    .mem_ready (mem_ready),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .AdrSrc    (AdrSrc),
    .IRWrite   (IRWrite),
    .PCWrite   (PCWrite),
    .RegWrite  (RegWrite),
    .ALUSrcA   (ALUSrcA),
    .ALUSrcB   (ALUSrcB),
    .ALUOp     (ALUOp),
    .ResultSrc (ResultSrc),
    .illegal   (illegal),
    .state_o   (state_o)
`ifdef PERF_CNT_EN
    ,
    .instret   (instret)
`endif
  );

  function automatic vec_t v(logic [6:0] op, logic z, logic r, logic [3:0] st, logic [14:0] out);
    vec_t t;
    t.op = op; t.zero = z; t.rdy = r; t.st = st; t.out = out;
    return t;
  endfunction

  task automatic check_now(string name, logic [3:0] exp_st, logic [14:0] exp_out);
    logic [14:0] got;
    got = {mem_req, mem_we, AdrSrc, IRWrite, PCWrite, RegWrite,
           ALUSrcA, ALUSrcB, ALUOp, ResultSrc, illegal};
    checks++;
    if (state_o !== exp_st || got !== exp_out) begin
      failures++;
      $display("FAIL %s: state=%0d outs=%b, expected state=%0d outs=%b",
               name, state_o, got, exp_st, exp_out);
    end
  endtask

  // Called at posedge+1: drive inputs, compare at the falling edge, step to next posedge+1.
  task automatic apply(string name, vec_t t);
    opcode    = t.op;
    zero      = t.zero;
    mem_ready = t.rdy;
    @(negedge clk);
    check_now(name, t.st, t.out);
    if (t.st == 4'd4 || t.st == 4'd7 || t.st == 4'd8 || (t.st == 4'd5 && t.rdy)) retired++;
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut(string name);
    rst_n     = 1'b0;
    opcode    = '0;
    zero      = 1'b0;
    mem_ready = 1'b0;
    #2;
    check_now(name, 4'd0, O_FW);
    retired = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    // Back-to-back R-type, LW (2 waits), SW, BEQ taken, BEQ not taken.
    tbl.push_back(v(RT, 0, 0, 0, O_FW));
    tbl.push_back(v(RT, 0, 1, 0, O_FR));
    tbl.push_back(v(RT, 1, 1, 1, O_DEC));
    tbl.push_back(v(RT, 0, 1, 6, O_EX));
    tbl.push_back(v(RT, 0, 1, 7, O_AWB));
    tbl.push_back(v(LW, 0, 1, 0, O_FR));
    tbl.push_back(v(LW, 0, 0, 1, O_DEC));
    tbl.push_back(v(LW, 0, 1, 2, O_MA));
    tbl.push_back(v(LW, 0, 0, 3, O_MR));
    tbl.push_back(v(LW, 0, 0, 3, O_MR));
    tbl.push_back(v(LW, 0, 1, 3, O_MR));
    tbl.push_back(v(LW, 0, 0, 4, O_MWB));
    tbl.push_back(v(SW, 0, 1, 0, O_FR));
    tbl.push_back(v(SW, 0, 0, 1, O_DEC));
    tbl.push_back(v(SW, 0, 0, 2, O_MA));
    tbl.push_back(v(SW, 0, 1, 5, O_MW));
    tbl.push_back(v(BQ, 0, 1, 0, O_FR));
    tbl.push_back(v(BQ, 0, 0, 1, O_DEC));
    tbl.push_back(v(BQ, 1, 0, 8, O_BR1));
    tbl.push_back(v(BQ, 1, 1, 0, O_FR));
    tbl.push_back(v(BQ, 0, 0, 1, O_DEC));
    tbl.push_back(v(BQ, 0, 0, 8, O_BR0));
    tbl.push_back(v(RT, 0, 0, 0, O_FW));

    reset_dut("reset_state");
    foreach (tbl[i]) apply($sformatf("vec%0d", i), tbl[i]);
`ifdef PERF_CNT_EN
    checks++;
    if (instret !== 4'(retired)) begin
      failures++;
      $display("FAIL instret_table: got %0d expected %0d", instret, 4'(retired));
    end
`endif

    // Illegal opcode: ILLEGAL at cycle 2, held with no requests or writes.
    reset_dut("reset_before_illegal");
    apply("ill_fetch", v(BAD, 0, 1, 0, O_FR));
    apply("ill_decode", v(BAD, 0, 0, 1, O_DEC));
    for (int i = 0; i < 20; i++) apply($sformatf("ill_hold%0d", i), v(BAD, 1'(i % 2), 1, 9, O_ILL));
    reset_dut("ill_reset");
    apply("ill_after_reset", v(RT, 0, 0, 0, O_FW));

    // Reset during a stalled MEMWRITE drops mem_we at once.
    reset_dut("reset_before_sw");
    apply("sw_fetch", v(SW, 0, 1, 0, O_FR));
    apply("sw_decode", v(SW, 0, 0, 1, O_DEC));
    apply("sw_memadr", v(SW, 0, 0, 2, O_MA));
    apply("sw_wait0", v(SW, 0, 0, 5, O_MW));
    apply("sw_wait1", v(SW, 0, 0, 5, O_MW));
`ifdef PERF_CNT_EN
    saved_instret = instret;
`endif
    reset_dut("sw_mid_reset");
    apply("sw_restart", v(SW, 0, 0, 0, O_FW));
`ifdef PERF_CNT_EN
    checks++;
    if (instret !== saved_instret) begin
      failures++;
      $display("FAIL instret_mid_reset: got %0d expected %0d", instret, saved_instret);
    end

    // 17 stores into a 4-bit counter wrap to 1.
    reset_dut("reset_before_wrap");
    for (int n = 0; n < 17; n++) begin
      apply("wrap_fetch", v(SW, 0, 1, 0, O_FR));
      apply("wrap_decode", v(SW, 0, 0, 1, O_DEC));
      apply("wrap_memadr", v(SW, 0, 0, 2, O_MA));
      apply("wrap_memwrite", v(SW, 0, 1, 5, O_MW));
    end
    checks++;
    if (instret !== 4'd1) begin
      failures++;
      $display("FAIL instret_wrap: got %0d expected 1", instret);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Main control FSM for the multicycle core. It sequences fetch, decode, execute, memory and writeback for the R-type, LW, SW and BEQ subset. It drives the datapath muxes and generates the 2-bit ALUOp consumed by ALUControl. It also handshakes with the unified instruction/data memory port and stalls on wait states.

## Interface
- OPCODE_W, 7, opcode field width
- ALUOP_W, 2, ALUOp width fed to ALUControl
- CNT_W, 32, retired-instruction counter width (only with PERF_CNT_EN)

- clk  in  1  rising-edge clock
- rst_n  in  1  reset; one clock, reset asynchronous and active-low
- opcode  in  OPCODE_W  IR[6:0], valid from DECODE onward
- Zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current request this cycle
- mem_req  out  1  memory access request
- mem_we  out  1  write strobe, valid only with mem_req
- AdrSrc  out  1  0 = PC, 1 = ALUOut as memory address
- IRWrite  out  1  load IR (and OldPC)
- PCWrite  out  1  load PC
- RegWrite  out  1  register file write
- ALUSrcA  out  2  00 PC, 01 OldPC, 10 rs1
- ALUSrcB  out  2  00 rs2, 01 imm, 10 constant 4
- ALUOp  out  ALUOP_W  00 add, 01 sub, 10 funct-decoded
- ResultSrc  out  2  00 ALUOut, 01 mem data, 10 ALU result
- illegal  out  1  sticky illegal-opcode flag
- state_o  out  4  current state encoding, for debug
- instret  out  CNT_W  retired count (only with PERF_CNT_EN)

## Operation
- Decoded opcodes:
  - 0110011 is R-type.
  - 0000011 is LW.
  - 0100011 is SW.
  - 1100011 is BEQ.
  - Any other opcode is illegal.
- Outputs are decoded from state. The exceptions are IRWrite, PCWrite in FETCH and PCWrite in BRANCH, which are gated by mem_ready or Zero (Mealy). Unlisted outputs are 0.
- States, encodings 0 to 9, with outputs and transitions:
  - FETCH (0): mem_req=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10. IRWrite=PCWrite=mem_ready. Stays in FETCH until mem_ready, then goes to DECODE.
  - DECODE (1): ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch target into ALUOut). Goes to MEMADR for LW/SW, EXECUTE for R-type, BRANCH for BEQ, ILLEGAL otherwise.
  - MEMADR (2): ALUSrcA=10, ALUSrcB=01, ALUOp=00. Goes to MEMREAD for LW, MEMWRITE for SW.
  - MEMREAD (3): mem_req=1, AdrSrc=1. Waits for mem_ready, then goes to MEMWB.
  - MEMWB (4): ResultSrc=01, RegWrite=1. Goes to FETCH.
  - MEMWRITE (5): mem_req=1, mem_we=1, AdrSrc=1. Waits for mem_ready, then goes to FETCH.
  - EXECUTE (6): ALUSrcA=10, ALUSrcB=00, ALUOp=10. Goes to ALUWB.
  - ALUWB (7): ResultSrc=00, RegWrite=1. Goes to FETCH.
  - BRANCH (8): ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, PCWrite=Zero. Goes to FETCH.
  - ILLEGAL (9): illegal=1, all write enables 0. Terminal until reset.
- Unreachable encodings 10 to 15 go to FETCH on the next edge.
- Memory handshake:
  - mem_req stays high and AdrSrc/mem_we stay stable until the cycle mem_ready=1.
  - mem_ready outside FETCH, MEMREAD and MEMWRITE is ignored.

## Timing
- Reset values:
  - State is FETCH and illegal is 0.
  - instret is 0.
  - Because FETCH is entered at reset, mem_req=1 during reset. The memory must ignore requests while rst_n=0.
- Reset deassertion mid-instruction:
  - The FSM restarts at FETCH.
  - No partial write enable is emitted after reset asserts, since outputs follow the state asynchronously.
- Latency with zero-wait memory (mem_ready=1 on first request cycle):
  - R-type is 4 cycles.
  - LW is 5 cycles.
  - SW is 4 cycles.
  - BEQ is 3 cycles.
  - Each wait cycle adds 1.
- A retirement occurs on the clock edge leaving MEMWB, MEMWRITE (with mem_ready), ALUWB or BRANCH.

## Configuration
- PERF_CNT_EN defined: instret is present. It increments by 1 per retirement and wraps modulo 2^CNT_W. ILLEGAL never retires.
- PERF_CNT_EN undefined: the instret port and counter are absent, and all other behaviour is identical.

## Structure
- Shared package cpu_pkg holds:
  - the state enum;
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ;
  - ALUOp constants ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT;
  - the ALUSrcA, ALUSrcB and ResultSrc select encodings.
- One sub-module, instr_counter, isolates the PERF_CNT_EN counter. All other logic is a single FSM: a state register plus combinational next-state/output blocks.

## Test plan
- R-type 0110011, mem_ready=1: state sequence 0,1,6,7,0. ALUOp=10 in EXECUTE. RegWrite pulses once in ALUWB. instret advances by 1.
- LW with 2 wait cycles in MEMREAD: mem_req=1, AdrSrc=1 for 3 cycles. ResultSrc=01, RegWrite=1 in MEMWB. Total 7 cycles.
- BEQ with Zero=1, then BEQ with Zero=0: PCWrite=1 in BRANCH for the first and 0 for the second. ALUOp=01 both times. 3 cycles each.
- Opcode 1111111: enters ILLEGAL at cycle 2, illegal=1. No mem_req or RegWrite afterward. Holds for 20 cycles until rst_n pulses low, then FETCH with illegal=0.
- rst_n asserted mid-MEMWRITE with mem_ready=0: mem_we drops immediately. Restarts at FETCH after deassertion. instret unchanged.
- PERF_CNT_EN with CNT_W=4: 17 SW instructions leave instret=1 (wrap).
